// File: rtl/svc_rv_dmem_model.sv
// Byte-strobed data memory model for an RV core, with sticky misalignment flag and access counters.
// Defining SVC_RV_DMEM_BRAM_EN selects registered (BRAM) reads; otherwise reads are combinational (SRAM).
module svc_rv_dmem_model #(
    parameter int          DMEM_WORDS = 32,
    parameter logic [31:0] INIT_VALUE = 32'h00000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        dmem_ren,
    input  logic [31:0] dmem_raddr,
    output logic [31:0] dmem_rdata,
    output logic        dmem_rvalid,
    input  logic        dmem_we,
    input  logic [31:0] dmem_waddr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_wstrb,
    output logic        err,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
);
    localparam int AW = $clog2(DMEM_WORDS);

    logic [31:0]   mem [DMEM_WORDS];
    logic [AW-1:0] ridx;
    logic [AW-1:0] widx;
    logic          misaligned;
    logic          unused_addr_bits;

    // Upper address bits are dropped so accesses wrap modulo the memory size.
    assign ridx             = dmem_raddr[AW+1:2];
    assign widx             = dmem_waddr[AW+1:2];
    assign unused_addr_bits = ^{dmem_raddr[31:AW+2], dmem_waddr[31:AW+2]};

    assign misaligned = (dmem_ren && (dmem_raddr[1:0] != 2'b00)) ||
                        (dmem_we  && (dmem_waddr[1:0] != 2'b00));

    // NOTE: this array is reset explicitly, which rules out block-RAM inference; it is a
    // behavioural model, so deterministic contents after reset matter more than mapping.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DMEM_WORDS; i++) begin
                mem[i] <= INIT_VALUE;
            end
        end else if (dmem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (dmem_wstrb[b]) begin
                    // NOTE: non-blocking, so any same-edge read of this word still sees the old value.
                    mem[widx][8*b +: 8] <= dmem_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            err      <= 1'b0;
            rd_count <= 16'h0000;
            wr_count <= 16'h0000;
        end else begin
            if (misaligned) begin
                err <= 1'b1;
            end
            if (dmem_ren && (rd_count != 16'hFFFF)) begin
                rd_count <= rd_count + 16'd1;
            end
            if (dmem_we && (wr_count != 16'hFFFF)) begin
                wr_count <= wr_count + 16'd1;
            end
        end
    end

`ifdef SVC_RV_DMEM_BRAM_EN
    logic        rvalid_q;
    logic [31:0] rdata_q;

    // Data is captured at the request edge (read-first) and held until the next read.
    always_ff @(posedge clock) begin
        if (reset) begin
            rvalid_q <= 1'b0;
            rdata_q  <= 32'h0;
        end else begin
            rvalid_q <= dmem_ren;
            if (dmem_ren) begin
                rdata_q <= mem[ridx];
            end
        end
    end

    assign dmem_rvalid = rvalid_q;
    assign dmem_rdata  = rvalid_q ? rdata_q : 32'h0;
`else
    // Requests presented during reset are ignored, so no response is shown for them.
    assign dmem_rvalid = dmem_ren & ~reset;
    assign dmem_rdata  = dmem_rvalid ? mem[ridx] : 32'h0;
`endif

endmodule

// File: tb/tb_svc_rv_dmem_model.sv
// Scoreboard bench for svc_rv_dmem_model: stimulus pushes expected read data, a monitor pops on dmem_rvalid.
// Works for both the default SRAM build and the SVC_RV_DMEM_BRAM_EN build.
module tb_svc_rv_dmem_model;
    logic        clock = 1'b0;
    logic        reset;
    logic        dmem_ren;
    logic [31:0] dmem_raddr;
    logic [31:0] dmem_rdata;
    logic        dmem_rvalid;
    logic        dmem_we;
    logic [31:0] dmem_waddr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        err;
    logic [15:0] rd_count;
    logic [15:0] wr_count;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q [$];

    always #5 clock = ~clock;

    svc_rv_dmem_model #(
        .DMEM_WORDS(32),
        .INIT_VALUE(32'h00000000)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .dmem_ren   (dmem_ren),
        .dmem_raddr (dmem_raddr),
        .dmem_rdata (dmem_rdata),
        .dmem_rvalid(dmem_rvalid),
        .dmem_we    (dmem_we),
        .dmem_waddr (dmem_waddr),
        .dmem_wdata (dmem_wdata),
        .dmem_wstrb (dmem_wstrb),
        .err        (err),
        .rd_count   (rd_count),
        .wr_count   (wr_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: away from the active edge, compare every presented response against the queue.
    always @(negedge clock) begin
        if (reset !== 1'b1) begin
            if (dmem_rvalid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL rvalid_unexpected: got rdata %h with no read outstanding", dmem_rdata);
                end else begin
                    check("rdata", dmem_rdata, exp_q.pop_front());
                end
            end else begin
                check("rdata_idle", dmem_rdata, 32'h0);
            end
        end
    end

    task automatic set_idle();
        dmem_ren   = 1'b0;
        dmem_raddr = 32'h0;
        dmem_we    = 1'b0;
        dmem_waddr = 32'h0;
        dmem_wdata = 32'h0;
        dmem_wstrb = 4'h0;
    endtask

    // One clock of traffic; returns at posedge+1 with inputs idle.
    task automatic access(input bit ren, input logic [31:0] raddr, input logic [31:0] exp_rd,
                          input bit we, input logic [31:0] waddr, input logic [31:0] wdata,
                          input logic [3:0] wstrb);
        dmem_ren   = ren;
        dmem_raddr = raddr;
        dmem_we    = we;
        dmem_waddr = waddr;
        dmem_wdata = wdata;
        dmem_wstrb = wstrb;
        if (ren) exp_q.push_back(exp_rd);
        @(posedge clock);
        #1;
        set_idle();
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp_rd);
        access(1'b1, addr, exp_rd, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        access(1'b0, 32'h0, 32'h0, 1'b1, addr, data, strb);
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && exp_q.size() != 0; i++) begin
            @(posedge clock);
            #1;
        end
        check("drain_outstanding", 32'(exp_q.size()), 32'h0);
    endtask

    // Reset for one cycle with traffic presented, which must be ignored and not counted.
    task automatic pulse_reset();
        reset      = 1'b1;
        dmem_ren   = 1'b1;
        dmem_raddr = 32'h20;
        dmem_we    = 1'b1;
        dmem_waddr = 32'h20;
        dmem_wdata = 32'h12345678;
        dmem_wstrb = 4'hF;
        @(posedge clock);
        #1;
        reset = 1'b0;
        set_idle();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        set_idle();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // Dirty a word, then reset: contents, flag and counters must all return to reset state.
        wr(32'h10, 32'hCAFEF00D, 4'hF);
        pulse_reset();
        check("rst_err", {31'h0, err}, 32'h0);
        check("rst_rd_count", {16'h0, rd_count}, 32'h0);
        check("rst_wr_count", {16'h0, wr_count}, 32'h0);
        check("rst_rvalid", {31'h0, dmem_rvalid}, 32'h0);

        rd(32'h10, 32'h00000000);
        rd(32'h20, 32'h00000000);
        drain();
        check("init_err", {31'h0, err}, 32'h0);
        check("init_rd_count", {16'h0, rd_count}, 32'h2);
        check("init_wr_count", {16'h0, wr_count}, 32'h0);

        // Byte strobes, then an all-zero strobe that must not alter memory but still counts.
        wr(32'h08, 32'h11223344, 4'b0101);
        rd(32'h08, 32'h00220044);
        drain();
        check("strb_wr_count", {16'h0, wr_count}, 32'h1);
        wr(32'h08, 32'hFFFFFFFF, 4'b0000);
        wr(32'h08, 32'hA5A5A5A5, 4'b1000);
        rd(32'h08, 32'hA5220044);
        drain();
        check("strb0_wr_count", {16'h0, wr_count}, 32'h3);

        // Read-first collision on the same word.
        wr(32'h04, 32'hAAAAAAAA, 4'hF);
        access(1'b1, 32'h04, 32'hAAAAAAAA, 1'b1, 32'h04, 32'h55555555, 4'hF);
        rd(32'h04, 32'h55555555);
        drain();

        // Wrap-around: high address bits are ignored.
        wr(32'h80, 32'hDEADBEEF, 4'hF);
        rd(32'h00, 32'hDEADBEEF);
        rd(32'hFFFFFF80, 32'hDEADBEEF);
        drain();
        check("pre_mis_err", {31'h0, err}, 32'h0);

        // Misaligned read still returns the truncated word and sets a sticky flag.
        rd(32'h0A, 32'hA5220044);
        check("mis_err_set", {31'h0, err}, 32'h1);
        for (int i = 0; i < 5; i++) begin
            wr(32'h40 + 32'(i * 4), 32'h100 + 32'(i), 4'hF);
            rd(32'h40 + 32'(i * 4), 32'h100 + 32'(i));
        end
        drain();
        check("mis_err_sticky", {31'h0, err}, 32'h1);
        pulse_reset();
        check("mis_err_clear", {31'h0, err}, 32'h0);

        // Misaligned write lands on the truncated word.
        wr(32'h0E, 32'h01020304, 4'hF);
        check("mis_wr_err", {31'h0, err}, 32'h1);
        rd(32'h0C, 32'h01020304);
        rd(32'h20, 32'h00000000);
        drain();
        pulse_reset();

`ifdef SVC_RV_DMEM_BRAM_EN
        // A read in flight is dropped by a reset asserted on the following cycle.
        dmem_ren   = 1'b1;
        dmem_raddr = 32'h0C;
        @(posedge clock);
        #1;
        set_idle();
        pulse_reset();
        check("rst_drop_rvalid", {31'h0, dmem_rvalid}, 32'h0);
        check("rst_drop_rdata", dmem_rdata, 32'h0);
`endif

        // Read counter saturation.
        for (int i = 0; i < 65535; i++) begin
            rd(32'h0C, 32'h00000000);
        end
        drain();
        check("rd_count_max", {16'h0, rd_count}, 32'h0000FFFF);
        for (int i = 0; i < 5; i++) begin
            rd(32'h0C, 32'h00000000);
        end
        drain();
        check("rd_count_sat", {16'h0, rd_count}, 32'h0000FFFF);
        check("sat_wr_count", {16'h0, wr_count}, 32'h0);

        repeat (2) @(posedge clock);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/svc_rv_dmem_model.md
SVC_RV_DMEM_MODEL -- requirements
Module: svc_rv_dmem_model

Interface
REQ-001 SHALL have parameter DMEM_WORDS, default 32, number of 32-bit words; power of two, at least 2.
REQ-002 SHALL have parameter INIT_VALUE, default 32'h00000000, the value loaded into every word at reset.
REQ-003 SHALL have port clock, input, 1, clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, reset, synchronous, active-high.
REQ-005 SHALL have port dmem_ren, input, 1, read request.
REQ-006 SHALL have port dmem_raddr, input, 32, read byte address.
REQ-007 SHALL have port dmem_rdata, output, 32, read data.
REQ-008 SHALL have port dmem_rvalid, output, 1, dmem_rdata is valid.
REQ-009 SHALL have port dmem_we, input, 1, write request.
REQ-010 SHALL have port dmem_waddr, input, 32, write byte address.
REQ-011 SHALL have port dmem_wdata, input, 32, write data.
REQ-012 SHALL have port dmem_wstrb, input, 4, byte enables; bit n enables byte lane [8n+7:8n].
REQ-013 SHALL have port err, output, 1, sticky misaligned-access flag.
REQ-014 SHALL have port rd_count, output, 16, count of accepted reads.
REQ-015 SHALL have port wr_count, output, 16, count of accepted writes.

Function
REQ-016 SHALL compute the word index as addr[log2(DMEM_WORDS)+1:2] and ignore all higher bits, so accesses wrap modulo DMEM_WORDS.
REQ-017 SHALL update, on a write (dmem_we=1), only the byte lanes whose dmem_wstrb bit is 1.
REQ-018 SHALL treat a write with dmem_wstrb=4'b0000 as a no-op for memory contents but SHALL still count it in wr_count.
REQ-019 SHALL use read-first ordering when a read and a write hit the same word in the same cycle: the read returns the pre-write contents.
REQ-020 SHALL set err to 1 on the first edge where (dmem_ren and dmem_raddr[1:0]!=0) or (dmem_we and dmem_waddr[1:0]!=0).
REQ-021 SHALL hold err at 1 until reset, and SHALL still perform the misaligned access on the truncated word index.
REQ-022 SHALL increment rd_count on each edge where dmem_ren=1, and SHALL increment wr_count on each edge where dmem_we=1.
REQ-023 SHALL saturate rd_count and wr_count at 16'hFFFF rather than wrap.
REQ-024 SHALL drive dmem_rdata to 0 whenever dmem_rvalid=0.

Reset
REQ-025 SHALL, on an edge with reset=1, load every word with INIT_VALUE and clear dmem_rvalid, dmem_rdata, err, rd_count and wr_count to 0.
REQ-026 SHALL, on an edge with reset=1, ignore dmem_ren and dmem_we, and SHALL drop any read in flight.
REQ-027 SHALL not count accesses presented during reset.

Configuration
REQ-028 SHALL compile registered-read (BRAM) timing in when the macro SVC_RV_DMEM_BRAM_EN is defined.
REQ-029 SHALL, with SVC_RV_DMEM_BRAM_EN defined, register dmem_rvalid from dmem_ren with 1-cycle latency.
REQ-030 SHALL, with SVC_RV_DMEM_BRAM_EN defined, capture dmem_rdata at the request edge with read-first data, hold it until the next read, and show it only while dmem_rvalid=1.
REQ-031 SHALL, without SVC_RV_DMEM_BRAM_EN, use combinational (SRAM) reads: dmem_rvalid=dmem_ren and dmem_rdata=mem[raddr] in the same cycle.
REQ-032 SHALL, without SVC_RV_DMEM_BRAM_EN, commit writes at the clock edge so that a same-cycle read still returns the old value.

Verification
REQ-033 SHALL cover the reset scenario: reset, then read addr 0x10 -> dmem_rdata=INIT_VALUE, err=0, rd_count=1, wr_count=0.
REQ-034 SHALL cover byte-strobe writes: write 0x11223344 to 0x08 with wstrb=4'b0101 over INIT_VALUE=0, then read 0x08 -> 0x00220044, wr_count=1.
REQ-035 SHALL cover read-first collision: word 0x04 holds 0xAAAAAAAA, then a same-cycle write of 0x55555555 and read of 0x04 -> 0xAAAAAAAA; next read -> 0x55555555; in BRAM mode rvalid is 1 exactly one cycle after each ren.
REQ-036 SHALL cover wrap-around: DMEM_WORDS=32, write 0xDEADBEEF to 0x80, then read 0x00 -> 0xDEADBEEF.
REQ-037 SHALL cover misalignment: read 0x0A -> err=1 the next cycle, data from word 2; err stays 1 over 10 aligned accesses; reset -> err=0.
REQ-038 SHALL cover counter saturation and reset mid-read: 65540 reads -> rd_count=16'hFFFF; in BRAM mode, reset asserted the cycle after ren -> dmem_rvalid=0 and dmem_rdata=0.
